// File: rtl/mmio_pkg.sv
// Shared types and constants for the MMIO request bridge and its address decoder.
package mmio_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_e;

  // Read data returned with any error response unless overridden.
  localparam logic [31:0] ERR_RDATA_DEF = 32'h0000_0000;

  // Required value of addr[1:0] for a word-aligned access.
  localparam logic [1:0]  ALIGN_MASK    = 2'b00;

  // MMIO window seen by the decoder: addr & MMIO_MASK == MMIO_BASE.
  localparam logic [31:0] MMIO_BASE     = 32'h4000_0000;
  localparam logic [31:0] MMIO_MASK     = 32'hFFFF_0000;

endpackage

// File: rtl/mmio_addr.sv
// MMIO address decoder: flags addresses that fall inside the device window.
module mmio_addr
  import mmio_pkg::*;
(
  input  logic [31:0] addr_i,
  output logic        is_mmio_o
);

  // Window match on the upper address bits.
  always_comb begin
    is_mmio_o = ((addr_i & MMIO_MASK) == MMIO_BASE);
  end

endmodule

// File: rtl/mmio_req_bridge.sv
// Converts one-shot MMIO requests into level-held device strobes and a
// single-cycle response, with local decode/alignment rejection and a timeout.
module mmio_req_bridge
  import mmio_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 1024,
  parameter int unsigned CNT_W          = 11,
  parameter logic [31:0] ERR_RDATA      = ERR_RDATA_DEF
) (
  input  logic        sys_clk,
  input  logic        rst,
  input  logic        req_valid,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        req_ready,
  output logic        resp_valid,
  output logic        resp_err,
  output logic [31:0] resp_rdata,
  output logic        mmio_read,
  output logic        mmio_write,
  output logic [31:0] mmio_addr,
  output logic [31:0] mmio_write_data,
  input  logic        mmio_read_done,
  input  logic        mmio_write_done,
  input  logic [31:0] mmio_read_data
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  state_e            state_q, state_d;
  logic              wr_q, wr_d;
  logic [31:0]       addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [31:0]       rdata_q, rdata_d;
  logic              err_q, err_d;

  logic              is_mmio;
  logic              accept;
  logic              local_err;
  logic              done_match;
  logic              timeout;

  mmio_addr u_addr_dec (
    .addr_i    (req_addr),
    .is_mmio_o (is_mmio)
  );

  // Shared decode terms: transfer, local rejection, matching done, timeout.
  always_comb begin
    accept     = req_valid && (state_q == IDLE);
    local_err  = !is_mmio || (req_addr[1:0] != ALIGN_MASK);
    done_match = wr_q ? mmio_write_done : mmio_read_done;
    timeout    = (cnt_q == CNT_LAST);
  end

  // State register.
  always_ff @(posedge sys_clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; a done in the timeout cycle still counts as completion.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = local_err ? RESP : BUSY;
        end
      end
      BUSY: begin
        if (done_match || timeout) begin
          state_d = RESP;
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Output decode from the current state and the latched direction.
  always_comb begin
    req_ready       = (state_q == IDLE);
    resp_valid      = (state_q == RESP);
    mmio_read       = (state_q == BUSY) && !wr_q;
    mmio_write      = (state_q == BUSY) &&  wr_q;
    mmio_addr       = addr_q;
    mmio_write_data = wdata_q;
    resp_err        = err_q;
    resp_rdata      = rdata_q;
  end

  // Next values for the request latch, timeout counter and response registers.
  always_comb begin
    wr_d    = wr_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    cnt_d   = cnt_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    unique case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (accept) begin
          wr_d    = req_write;
          addr_d  = req_addr;
          wdata_d = req_wdata;
          if (local_err) begin
            err_d   = 1'b1;
            rdata_d = ERR_RDATA;
          end
        end
      end
      BUSY: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (done_match) begin
          err_d   = 1'b0;
          rdata_d = wr_q ? 32'h0000_0000 : mmio_read_data;
        end else if (timeout) begin
          err_d   = 1'b1;
          rdata_d = ERR_RDATA;
        end
      end
      RESP: begin
        cnt_d = '0;
      end
      default: begin
        cnt_d = '0;
      end
    endcase
  end

  // Request latch, timeout counter and response registers.
  always_ff @(posedge sys_clk) begin
    if (rst) begin
      wr_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      cnt_q   <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      wr_q    <= wr_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

endmodule

// File: tb/tb_mmio_req_bridge.sv
// Directed and randomized bench for mmio_req_bridge with a transaction-level model.
module tb_mmio_req_bridge;

  localparam int T = 16;

  logic        sys_clk = 1'b0;
  logic        rst;
  logic        req_valid, req_write;
  logic [31:0] req_addr, req_wdata;
  logic        req_ready, resp_valid, resp_err;
  logic [31:0] resp_rdata;
  logic        mmio_read, mmio_write;
  logic [31:0] mmio_addr, mmio_write_data;
  logic        mmio_read_done, mmio_write_done;
  logic [31:0] mmio_read_data;

  int checks = 0;
  int passed = 0;

  mmio_req_bridge #(
    .TIMEOUT_CYCLES (T),
    .CNT_W          (5),
    .ERR_RDATA      (32'h0000_0000)
  ) dut (
    .sys_clk         (sys_clk),
    .rst             (rst),
    .req_valid       (req_valid),
    .req_write       (req_write),
    .req_addr        (req_addr),
    .req_wdata       (req_wdata),
    .req_ready       (req_ready),
    .resp_valid      (resp_valid),
    .resp_err        (resp_err),
    .resp_rdata      (resp_rdata),
    .mmio_read       (mmio_read),
    .mmio_write      (mmio_write),
    .mmio_addr       (mmio_addr),
    .mmio_write_data (mmio_write_data),
    .mmio_read_done  (mmio_read_done),
    .mmio_write_done (mmio_write_done),
    .mmio_read_data  (mmio_read_data)
  );

  always #5 sys_clk = ~sys_clk;

  // Device window: 0x4000_0000 .. 0x4000_FFFF.
  function automatic bit in_win(input logic [31:0] a);
    return (a >= 32'h4000_0000) && (a < 32'h4001_0000);
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // One request from IDLE; the device asserts the matching done in strobe
  // cycle done_at (0 = never) and the opposite done in cycle wrong_at.
  task automatic txn(input logic wr, input logic [31:0] addr, input logic [31:0] wd,
                     input logic [31:0] rd, input int done_at, input int wrong_at);
    bit          lerr;
    int          exp_str, exp_resp;
    logic        exp_err;
    logic [31:0] exp_rd;
    int          str_cnt = 0;
    int          resp_at = -1;
    int          bad = 0;
    lerr = !in_win(addr) || (addr[1:0] != 2'b00);
    if (lerr) begin
      exp_str = 0; exp_resp = 1; exp_err = 1'b1; exp_rd = 32'h0;
    end else if (done_at >= 1 && done_at <= T) begin
      exp_str = done_at; exp_resp = done_at + 1; exp_err = 1'b0;
      exp_rd = wr ? 32'h0 : rd;
    end else begin
      exp_str = T; exp_resp = T + 1; exp_err = 1'b1; exp_rd = 32'h0;
    end
    check("ready_before_req", req_ready, 1);
    req_valid = 1'b1; req_write = wr; req_addr = addr; req_wdata = wd;
    @(posedge sys_clk); #1;
    req_valid = 1'b0; req_write = ~wr; req_addr = $urandom; req_wdata = $urandom;
    for (int c = 1; c <= T + 8 && resp_at < 0; c++) begin
      mmio_read_done  = (!wr && c == done_at) || (wr && c == wrong_at);
      mmio_write_done = (wr && c == done_at) || (!wr && c == wrong_at);
      mmio_read_data  = (c == done_at) ? rd : $urandom;
      @(negedge sys_clk);
      if (mmio_read || mmio_write) begin
        str_cnt++;
        if (mmio_read !== !wr || mmio_write !== wr || mmio_addr !== addr) bad++;
        if (wr && mmio_write_data !== wd) bad++;
      end
      if (req_ready !== 1'b0) bad++;
      if (resp_valid === 1'b1) begin
        resp_at = c;
        check("resp_err", resp_err, exp_err);
        check("resp_rdata", resp_rdata, exp_rd);
      end
      @(posedge sys_clk); #1;
    end
    mmio_read_done = 1'b0; mmio_write_done = 1'b0;
    check("strobe_cycles", str_cnt, exp_str);
    check("resp_cycle", resp_at, exp_resp);
    check("hold_and_ready_low", bad, 0);
    check("resp_one_cycle", resp_valid, 0);
    check("ready_after_resp", req_ready, 1);
  endtask

  initial begin
    int rc;
    logic [31:0] a;
    rst = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0;
    mmio_read_done = 1'b0; mmio_write_done = 1'b0; mmio_read_data = '0;
    repeat (3) @(posedge sys_clk);
    #1 rst = 1'b0;
    @(negedge sys_clk);
    check("rst_ready", req_ready, 1);
    check("rst_resp_valid", resp_valid, 0);
    check("rst_resp_err", resp_err, 0);
    check("rst_resp_rdata", resp_rdata, 0);
    check("rst_strobes", {mmio_read, mmio_write}, 0);
    check("rst_addr", mmio_addr, 0);
    check("rst_wdata", mmio_write_data, 0);
    @(posedge sys_clk); #1;

    // Read with done on the 3rd strobe cycle.
    txn(1'b0, 32'h4000_0004, 32'h0, 32'hCAFE_0001, 3, 0);
    // Write with done in the first strobe cycle, then a back-to-back read.
    txn(1'b1, 32'h4000_0010, 32'h55AA_55AA, 32'h0, 1, 0);
    txn(1'b0, 32'h4000_0020, 32'h0, 32'h1234_5678, 2, 0);
    // Local rejections: outside the window, and misaligned inside it.
    txn(1'b0, 32'h1000_0000, 32'h0, 32'hDEAD_BEEF, 1, 0);
    txn(1'b1, 32'h4000_0002, 32'hFFFF_FFFF, 32'h0, 1, 0);
    // Device never answers; then done exactly in the timeout cycle.
    txn(1'b0, 32'h4000_0100, 32'h0, 32'h0, 0, 0);
    txn(1'b1, 32'h4000_0104, 32'hA5A5_0000, 32'h0, T, 0);
    // Mismatched done during a read is ignored.
    txn(1'b0, 32'h4000_0200, 32'h0, 32'h0BAD_F00D, 5, 2);

    // Reset in the second BUSY cycle aborts without a response.
    req_valid = 1'b1; req_write = 1'b0; req_addr = 32'h4000_0300; req_wdata = '0;
    @(posedge sys_clk); #1;
    req_valid = 1'b0;
    @(posedge sys_clk); #1;
    rst = 1'b1;
    @(posedge sys_clk); #1;
    rst = 1'b0;
    check("rst_mid_strobes", {mmio_read, mmio_write}, 0);
    check("rst_mid_ready", req_ready, 1);
    check("rst_mid_resp", resp_valid, 0);
    rc = 0;
    mmio_read_done = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge sys_clk);
      if (resp_valid === 1'b1 || mmio_read === 1'b1) rc++;
      @(posedge sys_clk); #1;
    end
    mmio_read_done = 1'b0;
    check("rst_mid_no_resp", rc, 0);
    txn(1'b0, 32'h4000_0300, 32'h0, 32'h7777_0001, 2, 0);

    // Randomized transactions.
    for (int i = 0; i < 24; i++) begin
      rc = $urandom_range(0, 9);
      if (rc < 6)      a = 32'h4000_0000 + ($urandom_range(0, 16383) << 2);
      else if (rc < 8) a = 32'h4000_0000 + ($urandom_range(0, 16383) << 2) + $urandom_range(1, 3);
      else             a = 32'h8000_0000 | ($urandom & 32'h0FFF_FFFC);
      txn(1'($urandom_range(0, 1)), a, $urandom, $urandom,
          $urandom_range(1, 20), $urandom_range(0, 20));
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
